fp_round_pipe: RTL
==================

Name: fp_round_pipe

Overview:
- Parametrised, pipelined rounding stage for the DLFloat16 FPU datapath.
- Takes an unrounded result in the form sign, exponent, mantissa plus extra low bits, and returns a packed float rounded under a per-operation rounding mode.
- Adds a valid/ready handshake with backpressure, overflow saturation and exception flags.
- Sits between the add/mul normalisers and the FPU result register.

Parameters:
- EXP_W, 6, exponent width (bias = 2^(EXP_W-1)-1).
- MAN_W, 9, stored fraction width.
- GRS_W, 4, extra low-order bits below the fraction LSB (GRS_W >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage can accept input.
- in_data  in  1+EXP_W+MAN_W+GRS_W  {sign, exp, frac, extra}; 20 bits at defaults.
- in_rm  in  3  rounding mode, captured with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  1+EXP_W+MAN_W  rounded result; 16 bits at defaults.
- out_flags  out  3  {NV, OF, NX} for the current result.
- sticky_flags  out  3  accumulated flags (see Optional Feature).
- flags_clr  in  1  clears sticky_flags.

Behaviour:
- Reset values: all outputs 0. in_ready=1 once reset deasserts. Both pipeline valid bits are cleared. Reset mid-operation discards in-flight words; no output is produced for them.
- Pipeline: 2 stages, latency 2 cycles from an accepted input to out_valid.
  - S1 registers sign, {exp,frac}, the round-up decision and pre-flags.
  - S2 registers the incremented/saturated result and final flags.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - S2 loads when empty or transferring. S1 advances when S2 loads.
  - in_ready = !s1_valid || s1_advance.
  - out_data and out_flags hold stable while out_valid && !out_ready.
  - Full throughput: 1 word per cycle with out_ready held high.
- Rounding modes:
  - 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
  - 101-111 are invalid: round as RNE and set NV.
- Decision bits:
  - L = frac[0], G = extra[GRS_W-1], S = OR of extra[GRS_W-2:0].
  - inexact = G|S.
  - round-up: RNE: G&(S|L). RTZ: 0. RDN: sign&inexact. RUP: !sign&inexact. RMM: G.
- Arithmetic: {exp,frac} + round-up is an (EXP_W+MAN_W)-bit add. A fraction carry propagates into the exponent, so no separate renormalisation step is needed.
- Special encoding: exp all-ones with frac all-ones is NaN/Inf.
  - A special input passes through unchanged with sign kept, flags 0.
- Overflow: a result reaching the special encoding from a non-special input saturates to max finite ±{all-ones exp, frac all-ones minus 1}. OF=1, NX=1.
- Zero: input exp==0 gives signed zero output. NX=1 if frac|extra is nonzero.
- NX = inexact for all other cases.
- Sign always passes through unchanged.

Optional Feature:
- Macro FP_ROUND_STICKY_FLAGS_EN.
- Defined:
  - sticky_flags |= out_flags on each output transfer.
  - flags_clr zeroes sticky_flags next cycle.
  - When clr and a transfer happen in the same cycle, the transfer's flags survive, so the register holds exactly out_flags.
- Undefined: sticky_flags is tied to 0 and flags_clr is ignored. The ports remain.

Decomposition:
- Package fp_round_pkg holds:
  - rounding-mode localparams RM_RNE..RM_RMM;
  - flag bit indices NV/OF/NX;
  - DLFloat16 default widths;
  - a function computing the round-up decision.
- One sub-module, fp_round_decide: the combinational L/G/S extraction, mode decision and special/zero detection feeding S1.
- Pipeline, handshake and flag accumulation stay in the top level.

Test Plan:
- Carry into exponent: in_data=20'b0_101110_111111111_1111.
  - rm=001 (RTZ) -> out 16'h5DFF, flags NX.
  - rm=011 (RUP) -> 16'h5E00, NX.
  - rm=000 (RNE) -> 16'h5E00, NX.
- RNE ties:
  - 0_100000_000000001_1000 -> 16'h4002, NX.
  - 0_100000_000000000_1000 -> 16'h4000, NX.
  - Same words with rm=100 (RMM) -> 16'h4002 and 16'h4001.
- Overflow/special:
  - 0_111111_111111110_1111, rm=011 -> 16'h7FFE, flags {0,1,1}.
  - 1_111111_111111111_0000 -> 16'hFFFF, flags 0.
  - Negative word with rm=010 rounds away from zero; with rm=011 it truncates.
- Invalid mode: rm=111 on the tie word 0_100000_000000001_1000 -> 16'h4002, flags {1,0,1}.
- Backpressure: stream 8 words with out_ready toggling every cycle.
  - Outputs arrive in order with no drops or duplicates.
  - out_data is stable while stalled.
  - in_ready drops only when both stages are full.
  - Latency is 2 cycles with out_ready=1.
- Reset and sticky flags: assert rst with 2 words in flight -> out_valid=0 immediately, nothing emitted after release. With FP_ROUND_STICKY_FLAGS_EN, OF+NX accumulate to 3'b011, and flags_clr coincident with a NX-only transfer leaves 3'b001.

Source files
------------

// File: rtl/fp_round_pkg.sv
// Shared definitions for the DLFloat16 rounding stage: rounding-mode codes,
// flag bit positions, default field widths and the round-up decision.
package fp_round_pkg;

  // DLFloat16 field widths
  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;
  localparam int DLF_GRS_W = 4;

  // Rounding-mode codes; anything above RM_RMM is invalid
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Bit positions inside a {NV, OF, NX} flag vector
  localparam int FLAG_NX = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_NV = 2;

  // Round-up decision from lsb/guard/sticky; invalid modes behave as RNE
  function automatic logic round_up_decide(input logic [2:0] rm,
                                           input logic       sign,
                                           input logic       l,
                                           input logic       g,
                                           input logic       s);
    logic inexact;
    inexact = g | s;
    case (rm)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign & inexact;
      RM_RUP:  return !sign & inexact;
      RM_RMM:  return g;
      default: return g & (s | l);
    endcase
  endfunction

  function automatic logic rm_invalid(input logic [2:0] rm);
    return rm > RM_RMM;
  endfunction

endpackage

// File: rtl/fp_round_pipe_decide.sv
// Combinational front end of the rounding stage: splits the unrounded word
// into fields, extracts L/G/S, decides round-up and classifies special/zero
// inputs together with their pre-flags.
module fp_round_decide
  import fp_round_pkg::*;
#(
  parameter int EXP_W = DLF_EXP_W,
  parameter int MAN_W = DLF_MAN_W,
  parameter int GRS_W = DLF_GRS_W
) (
  input  logic [EXP_W+MAN_W+GRS_W:0] i_data,
  input  logic [2:0]                 i_rm,
  output logic                       o_sign,
  output logic [EXP_W+MAN_W-1:0]     o_mag,
  output logic                       o_round_up,
  output logic                       o_special,
  output logic                       o_zero,
  output logic                       o_nv,
  output logic                       o_nx
);

  logic             w_sign;
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;
  logic [GRS_W-1:0] w_extra;
  logic             w_l;
  logic             w_g;
  logic             w_s;

  assign w_sign  = i_data[EXP_W+MAN_W+GRS_W];
  assign w_exp   = i_data[MAN_W+GRS_W +: EXP_W];
  assign w_frac  = i_data[GRS_W +: MAN_W];
  assign w_extra = i_data[GRS_W-1:0];

  assign w_l = w_frac[0];
  assign w_g = w_extra[GRS_W-1];
  assign w_s = |w_extra[GRS_W-2:0];

  // all-ones exponent with all-ones fraction is the NaN/Inf encoding
  assign o_special = (&w_exp) & (&w_frac);
  assign o_zero    = (w_exp == '0);

  assign o_sign     = w_sign;
  assign o_mag      = {w_exp, w_frac};
  assign o_round_up = !o_special && !o_zero &&
                      round_up_decide(i_rm, w_sign, w_l, w_g, w_s);

  // special inputs pass through silently, so they never raise NV or NX
  assign o_nv = !o_special && rm_invalid(i_rm);
  assign o_nx = o_special ? 1'b0 :
                o_zero    ? ((|w_frac) | (|w_extra)) :
                            (w_g | w_s);

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage pipelined rounding stage for the DLFloat16 FPU datapath with a
// valid/ready handshake, overflow saturation and {NV, OF, NX} flags.
// Optional macro FP_ROUND_STICKY_FLAGS_EN enables the accumulated
// sticky_flags register; without it sticky_flags reads 0.
module fp_round_pipe
  import fp_round_pkg::*;
#(
  parameter int EXP_W = DLF_EXP_W,
  parameter int MAN_W = DLF_MAN_W,
  parameter int GRS_W = DLF_GRS_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W+GRS_W:0] in_data,
  input  logic [2:0]                 in_rm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out_data,
  output logic [2:0]                 out_flags,
  output logic [2:0]                 sticky_flags,
  input  logic                       flags_clr
);

  localparam int MAG_W = EXP_W + MAN_W;
  localparam logic [MAG_W-1:0] MAG_SPECIAL = {MAG_W{1'b1}};
  localparam logic [MAG_W-1:0] MAG_MAX     = {{(MAG_W-1){1'b1}}, 1'b0};

  // decision logic outputs
  logic             w_sign;
  logic [MAG_W-1:0] w_mag;
  logic             w_round_up;
  logic             w_special;
  logic             w_zero;
  logic             w_nv;
  logic             w_nx;

  // stage 1 registers
  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [MAG_W-1:0] r_s1_mag;
  logic             r_s1_rup;
  logic             r_s1_special;
  logic             r_s1_zero;
  logic             r_s1_nv;
  logic             r_s1_nx;

  // stage 2 registers
  logic             r_s2_valid;
  logic [MAG_W:0]   r_out_data;
  logic [2:0]       r_out_flags;

  // handshake
  logic             w_s2_load;
  logic             w_s1_take;
  logic             w_out_fire;

  // stage 2 datapath
  logic [MAG_W-1:0] w_sum;
  logic [MAG_W:0]   w_res_data;
  logic [2:0]       w_res_flags;

  fp_round_decide #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W),
    .GRS_W(GRS_W)
  ) u_decide (
    .i_data    (in_data),
    .i_rm      (in_rm),
    .o_sign    (w_sign),
    .o_mag     (w_mag),
    .o_round_up(w_round_up),
    .o_special (w_special),
    .o_zero    (w_zero),
    .o_nv      (w_nv),
    .o_nx      (w_nx)
  );

  assign w_out_fire = r_s2_valid && out_ready;
  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_take  = !r_s1_valid || w_s2_load;
  assign in_ready   = !rst && w_s1_take;
  assign out_valid  = r_s2_valid;
  assign out_data   = r_out_data;
  assign out_flags  = r_out_flags;

  // Stage 1 occupancy: refilled whenever it is empty or draining into S2
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_take) begin
      r_s1_valid <= in_valid;
    end
  end

  // Stage 1 payload capture on an accepted input word
  // NOTE: payload registers carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (w_s1_take && in_valid) begin
      r_s1_sign    <= w_sign;
      r_s1_mag     <= w_mag;
      r_s1_rup     <= w_round_up;
      r_s1_special <= w_special;
      r_s1_zero    <= w_zero;
      r_s1_nv      <= w_nv;
      r_s1_nx      <= w_nx;
    end
  end

  // the fraction carry ripples into the exponent, so no renormalisation
  assign w_sum = r_s1_mag + {{(MAG_W-1){1'b0}}, r_s1_rup};

  // Final result selection: pass-through, signed zero, saturation or rounded
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    w_res_data           = {r_s1_sign, w_sum};
    w_res_flags          = '0;
    w_res_flags[FLAG_NV] = r_s1_nv;
    w_res_flags[FLAG_NX] = r_s1_nx;
    if (r_s1_special) begin
      w_res_data  = {r_s1_sign, r_s1_mag};
      w_res_flags = '0;
    end else if (r_s1_zero) begin
      w_res_data = {r_s1_sign, {MAG_W{1'b0}}};
    end else if (w_sum == MAG_SPECIAL) begin
      w_res_data           = {r_s1_sign, MAG_MAX};
      w_res_flags[FLAG_OF] = 1'b1;
      w_res_flags[FLAG_NX] = 1'b1;
    end
  end

  // Stage 2 / output register: holds its value while stalled downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data  <= w_res_data;
        r_out_flags <= w_res_flags;
      end
    end
  end

`ifdef FP_ROUND_STICKY_FLAGS_EN
  logic [2:0] r_sticky;

  // Sticky accumulation; a clear never loses the flags transferring with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= '0;
    end else if (flags_clr) begin
      r_sticky <= w_out_fire ? r_out_flags : 3'b000;
    end else if (w_out_fire) begin
      r_sticky <= r_sticky | r_out_flags;
    end
  end

  assign sticky_flags = r_sticky;
`else
  logic w_unused_clr;
  assign w_unused_clr = flags_clr;
  assign sticky_flags = 3'b000;
`endif

endmodule
